// File: rtl/div_arbiter_pkg.sv
// -----------------------------------------------------------------------------
// div_arbiter_pkg
//   Shared types and constants for the divider arbiter slice.
//   - state_e      : arbiter FSM states (IDLE_S, ISSUE_S, WAIT_S, RESP_S)
//   - DBZ_QUOTIENT : all-ones pattern returned as quotient on a zero divisor;
//                    users take the low WORD_W bits.
//   No ports (package).
// -----------------------------------------------------------------------------
package div_arbiter_pkg;

  typedef enum logic [1:0] {
    IDLE_S  = 2'd0,
    ISSUE_S = 2'd1,
    WAIT_S  = 2'd2,
    RESP_S  = 2'd3
  } state_e;

  // Widest operand this slice supports; quotient constant is sliced from it.
  localparam int MAX_WORD_W = 64;
  localparam logic [MAX_WORD_W-1:0] DBZ_QUOTIENT = {MAX_WORD_W{1'b1}};

endpackage : div_arbiter_pkg

// File: rtl/div_arbiter_if.sv
// -----------------------------------------------------------------------------
// div_arbiter_if
//   Requester-side bus of the divider arbiter: per-requester request channel
//   (valid/ready + packed operands) and response channel (valid/ready + shared
//   quotient/remainder/dbz).
//   modport master : client side (drives requests, accepts responses)
//   modport slave  : arbiter side
//   Parameters: WORD_W operand width, N_REQ number of requesters.
// -----------------------------------------------------------------------------
interface div_arbiter_if #(
  parameter int WORD_W = 8,
  parameter int N_REQ  = 4
);

  logic [N_REQ-1:0]        req_valid;
  logic [N_REQ-1:0]        req_ready;
  logic [N_REQ*WORD_W-1:0] req_dividend;
  logic [N_REQ*WORD_W-1:0] req_divisor;
  logic [N_REQ-1:0]        rsp_valid;
  logic [N_REQ-1:0]        rsp_ready;
  logic [WORD_W-1:0]       rsp_quotient;
  logic [WORD_W-1:0]       rsp_reminder;
  logic                    rsp_dbz;

  modport master (
    output req_valid, req_dividend, req_divisor, rsp_ready,
    input  req_ready, rsp_valid, rsp_quotient, rsp_reminder, rsp_dbz
  );

  modport slave (
    input  req_valid, req_dividend, req_divisor, rsp_ready,
    output req_ready, rsp_valid, rsp_quotient, rsp_reminder, rsp_dbz
  );

endinterface : div_arbiter_if

// File: rtl/div_rr_pick.sv
// -----------------------------------------------------------------------------
// div_rr_pick
//   Combinational round-robin picker. Scans req_valid_i starting at rr_ptr_i
//   with wrap-around and reports the first set index.
//   req_valid_i : request vector
//   rr_ptr_i    : index with highest priority this cycle
//   enable_i    : when low, grant_o is forced to zero (index still reported)
//   grant_o     : one-hot grant (or zero)
//   grant_id_o  : index of the winner
//   found_o     : some request is valid
// -----------------------------------------------------------------------------
module div_rr_pick #(
  parameter  int N_REQ = 4,
  localparam int ID_W  = $clog2(N_REQ)
) (
  input  logic [N_REQ-1:0] req_valid_i,
  input  logic [ID_W-1:0]  rr_ptr_i,
  input  logic             enable_i,
  output logic [N_REQ-1:0] grant_o,
  output logic [ID_W-1:0]  grant_id_o,
  output logic             found_o
);

  logic [ID_W:0]   sum_s;
  logic [ID_W-1:0] idx_s;
  logic [ID_W-1:0] win_s;
  logic            hit_s;

  // Wrap-around priority scan from the round-robin pointer.
  always_comb begin
    sum_s = {(ID_W+1){1'b0}};
    idx_s = {ID_W{1'b0}};
    win_s = {ID_W{1'b0}};
    hit_s = 1'b0;
    for (int i = 0; i < N_REQ; i++) begin
      sum_s = {1'b0, rr_ptr_i} + (ID_W+1)'(i);
      if (sum_s >= (ID_W+1)'(N_REQ)) begin
        sum_s = sum_s - (ID_W+1)'(N_REQ);
      end else begin
        sum_s = sum_s;
      end
      idx_s = sum_s[ID_W-1:0];
      if (!hit_s && req_valid_i[idx_s]) begin
        hit_s = 1'b1;
        win_s = idx_s;
      end else begin
        hit_s = hit_s;
      end
    end
  end

  // Turn the winning index into a gated one-hot grant.
  always_comb begin
    grant_o = {N_REQ{1'b0}};
    if (enable_i && hit_s) begin
      grant_o[win_s] = 1'b1;
    end else begin
      grant_o = {N_REQ{1'b0}};
    end
  end

  assign grant_id_o = win_s;
  assign found_o    = hit_s;

endmodule : div_rr_pick

// File: rtl/div_arbiter.sv
// -----------------------------------------------------------------------------
// div_arbiter
//   Round-robin scheduler sharing one iterative divider among N_REQ clients.
//   A request is accepted in IDLE (only while the divider is ready), issued
//   with a one-cycle start pulse, the divider result is captured and then held
//   on the winner's response channel until that client accepts it.
//
//   Ports:
//     clk_i, rst_n_i      clock, async active-low reset
//     bus (slave)         request/response channels (see div_arbiter_if)
//     grant_id_o          index of the request in flight
//     busy_o              high outside IDLE
//     div_start_o         one-cycle divider start
//     div_dividend_o/div_divisor_o  latched operands to the divider
//     div_ready_i         divider idle
//     div_valid_i         divider result pulse (only honoured in WAIT)
//     div_quotient_i/div_reminder_i divider results
//
//   Build option DIV_ARBITER_ZERO_CHECK_EN: a zero divisor is answered locally
//   (quotient all-ones, remainder = dividend, dbz=1) without starting the
//   divider. Without it the divider handles zero divisors and dbz is 0.
// -----------------------------------------------------------------------------
module div_arbiter
  import div_arbiter_pkg::*;
#(
  parameter  int WORD_W = 8,
  parameter  int N_REQ  = 4,
  localparam int ID_W   = $clog2(N_REQ)
) (
  input  logic              clk_i,
  input  logic              rst_n_i,
  div_arbiter_if.slave      bus,
  output logic [ID_W-1:0]   grant_id_o,
  output logic              busy_o,
  output logic              div_start_o,
  output logic [WORD_W-1:0] div_dividend_o,
  output logic [WORD_W-1:0] div_divisor_o,
  input  logic              div_ready_i,
  input  logic              div_valid_i,
  input  logic [WORD_W-1:0] div_quotient_i,
  input  logic [WORD_W-1:0] div_reminder_i
);

  state_e            state_q, state_d;
  logic [ID_W-1:0]   rr_ptr_q, rr_ptr_d;
  logic [ID_W-1:0]   id_q, id_d;
  logic [WORD_W-1:0] dividend_q, dividend_d;
  logic [WORD_W-1:0] divisor_q, divisor_d;
  logic [WORD_W-1:0] quot_q, quot_d;
  logic [WORD_W-1:0] rem_q, rem_d;
`ifdef DIV_ARBITER_ZERO_CHECK_EN
  logic              dbz_q, dbz_d;
  logic              zero_div_s;
`endif

  logic [N_REQ-1:0]  grant_s;
  logic [ID_W-1:0]   pick_id_s;
  logic              pick_found_s;
  logic              pick_en_s;
  logic              accept_s;
  logic [N_REQ-1:0]  id_onehot_s;
  logic              rsp_done_s;

  // Requests are only offered while idle and the divider can take one.
  assign pick_en_s = (state_q == IDLE_S) && div_ready_i;

  div_rr_pick #(
    .N_REQ (N_REQ)
  ) u_pick (
    .req_valid_i (bus.req_valid),
    .rr_ptr_i    (rr_ptr_q),
    .enable_i    (pick_en_s),
    .grant_o     (grant_s),
    .grant_id_o  (pick_id_s),
    .found_o     (pick_found_s)
  );

  assign accept_s    = pick_en_s && pick_found_s;
  assign id_onehot_s = {{(N_REQ-1){1'b0}}, 1'b1} << id_q;
  // Ready from other clients is ignored: only the granted index completes.
  assign rsp_done_s  = |(bus.rsp_ready & id_onehot_s);

`ifdef DIV_ARBITER_ZERO_CHECK_EN
  assign zero_div_s  = (divisor_q == {WORD_W{1'b0}});
`endif

  // Next-state and datapath update for the arbiter FSM.
  always_comb begin
    state_d    = state_q;
    rr_ptr_d   = rr_ptr_q;
    id_d       = id_q;
    dividend_d = dividend_q;
    divisor_d  = divisor_q;
    quot_d     = quot_q;
    rem_d      = rem_q;
`ifdef DIV_ARBITER_ZERO_CHECK_EN
    dbz_d      = dbz_q;
`endif
    case (state_q)
      IDLE_S: begin
        if (accept_s) begin
          state_d    = ISSUE_S;
          id_d       = pick_id_s;
          dividend_d = bus.req_dividend[int'(pick_id_s)*WORD_W +: WORD_W];
          divisor_d  = bus.req_divisor[int'(pick_id_s)*WORD_W +: WORD_W];
          if (pick_id_s == ID_W'(N_REQ-1)) begin
            rr_ptr_d = {ID_W{1'b0}};
          end else begin
            rr_ptr_d = pick_id_s + ID_W'(1);
          end
        end else begin
          state_d = IDLE_S;
        end
      end
      ISSUE_S: begin
`ifdef DIV_ARBITER_ZERO_CHECK_EN
        if (zero_div_s) begin
          // Answer locally; the divider is never started.
          quot_d  = DBZ_QUOTIENT[WORD_W-1:0];
          rem_d   = dividend_q;
          dbz_d   = 1'b1;
          state_d = RESP_S;
        end else begin
          dbz_d   = 1'b0;
          state_d = WAIT_S;
        end
`else
        state_d = WAIT_S;
`endif
      end
      WAIT_S: begin
        if (div_valid_i) begin
          quot_d  = div_quotient_i;
          rem_d   = div_reminder_i;
          state_d = RESP_S;
        end else begin
          state_d = WAIT_S;
        end
      end
      RESP_S: begin
        if (rsp_done_s) begin
          state_d = IDLE_S;
        end else begin
          state_d = RESP_S;
        end
      end
      default: begin
        state_d = IDLE_S;
      end
    endcase
  end

  // State and datapath registers, cleared asynchronously.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q    <= IDLE_S;
      rr_ptr_q   <= {ID_W{1'b0}};
      id_q       <= {ID_W{1'b0}};
      dividend_q <= {WORD_W{1'b0}};
      divisor_q  <= {WORD_W{1'b0}};
      quot_q     <= {WORD_W{1'b0}};
      rem_q      <= {WORD_W{1'b0}};
`ifdef DIV_ARBITER_ZERO_CHECK_EN
      dbz_q      <= 1'b0;
`endif
    end else begin
      state_q    <= state_d;
      rr_ptr_q   <= rr_ptr_d;
      id_q       <= id_d;
      dividend_q <= dividend_d;
      divisor_q  <= divisor_d;
      quot_q     <= quot_d;
      rem_q      <= rem_d;
`ifdef DIV_ARBITER_ZERO_CHECK_EN
      dbz_q      <= dbz_d;
`endif
    end
  end

  assign bus.req_ready    = grant_s;
  assign bus.rsp_valid    = (state_q == RESP_S) ? id_onehot_s : {N_REQ{1'b0}};
  assign bus.rsp_quotient = quot_q;
  assign bus.rsp_reminder = rem_q;
`ifdef DIV_ARBITER_ZERO_CHECK_EN
  assign bus.rsp_dbz      = dbz_q;
  assign div_start_o      = (state_q == ISSUE_S) && !zero_div_s;
`else
  assign bus.rsp_dbz      = 1'b0;
  assign div_start_o      = (state_q == ISSUE_S);
`endif
  assign grant_id_o       = id_q;
  assign busy_o           = (state_q != IDLE_S);
  assign div_dividend_o   = dividend_q;
  assign div_divisor_o    = divisor_q;

endmodule : div_arbiter

// File: tb/tb_div_arbiter.sv
// -----------------------------------------------------------------------------
// tb_div_arbiter
//   Directed + randomized bench for div_arbiter (WORD_W=8, N_REQ=4).
//   Contains a behavioural divider (result WORD_W+2 cycles after start) and a
//   reference model of round-robin order, results and latency.
// -----------------------------------------------------------------------------
module tb_div_arbiter;

  localparam int WORD_W = 8;
  localparam int N_REQ  = 4;
  localparam int ID_W   = 2;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  div_arbiter_if #(.WORD_W(WORD_W), .N_REQ(N_REQ)) bus_if ();

  logic [ID_W-1:0]   grant_id;
  logic              busy;
  logic              div_start;
  logic [WORD_W-1:0] div_dividend;
  logic [WORD_W-1:0] div_divisor;
  logic              div_ready;
  logic              div_valid;
  logic [WORD_W-1:0] div_quot;
  logic [WORD_W-1:0] div_rem;

  div_arbiter #(.WORD_W(WORD_W), .N_REQ(N_REQ)) dut (
    .clk_i          (clk),
    .rst_n_i        (rst_n),
    .bus            (bus_if),
    .grant_id_o     (grant_id),
    .busy_o         (busy),
    .div_start_o    (div_start),
    .div_dividend_o (div_dividend),
    .div_divisor_o  (div_divisor),
    .div_ready_i    (div_ready),
    .div_valid_i    (div_valid),
    .div_quotient_i (div_quot),
    .div_reminder_i (div_rem)
  );

  // Behavioural divider: result pulse WORD_W+2 cycles after the start cycle.
  int                dcnt;
  logic [WORD_W-1:0] dq, dr;
  logic              hold_rdy = 1'b0;
  logic              inj_valid = 1'b0;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dcnt <= 0;
      dq   <= '0;
      dr   <= '0;
    end else if (div_start && dcnt == 0) begin
      dcnt <= WORD_W + 2;
      dq   <= (div_divisor == 0) ? 8'hFF : div_dividend / div_divisor;
      dr   <= (div_divisor == 0) ? div_dividend : div_dividend % div_divisor;
    end else if (dcnt > 0) begin
      dcnt <= dcnt - 1;
    end
  end

  assign div_ready = (dcnt == 0) && !hold_rdy;
  assign div_valid = (dcnt == 1) || inj_valid;
  assign div_quot  = dq;
  assign div_rem   = dr;

  int total = 0;
  int bad   = 0;
  int model_ptr = 0;
  logic [N_REQ-1:0] pend = '0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic post(input int k, input logic [WORD_W-1:0] dd, input logic [WORD_W-1:0] dv);
    bus_if.req_dividend[k*WORD_W +: WORD_W] = dd;
    bus_if.req_divisor[k*WORD_W +: WORD_W]  = dv;
    pend[k] = 1'b1;
    bus_if.req_valid = pend;
  endtask

  // Wait for one acceptance and follow that transaction to the handshake.
  task automatic serve(input int bp);
    int n, lat, w, k;
    logic [WORD_W-1:0] dd, dv, eq, er;
    logic [N_REQ-1:0]  oh;
    logic              zc_hit;
    #1;
    n = 0;
    while (((bus_if.req_ready & bus_if.req_valid) == '0) && n < 60) begin
      tick();
      n++;
    end
    w = -1;
    for (int i = 0; i < N_REQ; i++) begin
      k = (model_ptr + i) % N_REQ;
      if (w < 0 && pend[k]) w = k;
    end
    if (w < 0) return;
    chk("req_ready_winner", 32'(bus_if.req_ready), 32'd1 << w);
    if ((bus_if.req_ready & bus_if.req_valid) == '0) return;
    dd = bus_if.req_dividend[w*WORD_W +: WORD_W];
    dv = bus_if.req_divisor[w*WORD_W +: WORD_W];
    model_ptr = (w + 1) % N_REQ;
`ifdef DIV_ARBITER_ZERO_CHECK_EN
    zc_hit = (dv == 0);
`else
    zc_hit = 1'b0;
`endif
    eq = (dv == 0) ? 8'hFF : dd / dv;
    er = (dv == 0) ? dd : dd % dv;
    tick();
    pend[w] = 1'b0;
    bus_if.req_valid = pend;
    chk("issue_start", 32'(div_start), 32'(!zc_hit));
    chk("issue_busy", 32'(busy), 32'd1);
    if (!zc_hit) begin
      chk("op_dividend", 32'(div_dividend), 32'(dd));
      chk("op_divisor", 32'(div_divisor), 32'(dv));
    end
    lat = 1;
    while (bus_if.rsp_valid == '0 && lat < 40) begin
      tick();
      lat++;
    end
    chk("rsp_latency", 32'(lat), zc_hit ? 32'd2 : 32'(WORD_W + 4));
    chk("rsp_valid", 32'(bus_if.rsp_valid), 32'd1 << w);
    chk("grant_id", 32'(grant_id), 32'(w));
    chk("quotient", 32'(bus_if.rsp_quotient), 32'(eq));
    chk("remainder", 32'(bus_if.rsp_reminder), 32'(er));
    chk("dbz", 32'(bus_if.rsp_dbz), 32'(zc_hit));
    oh = '0;
    oh[w] = 1'b1;
    for (int i = 0; i < bp; i++) begin
      bus_if.rsp_ready = ~oh;
      tick();
      chk("bp_rsp_valid", 32'(bus_if.rsp_valid), 32'(oh));
      chk("bp_quotient", 32'(bus_if.rsp_quotient), 32'(eq));
      chk("bp_remainder", 32'(bus_if.rsp_reminder), 32'(er));
      chk("bp_req_ready", 32'(bus_if.req_ready), 32'd0);
    end
    bus_if.rsp_ready = oh;
    tick();
    bus_if.rsp_ready = '0;
    chk("post_hs_busy", 32'(busy), 32'd0);
    chk("post_hs_rsp_valid", 32'(bus_if.rsp_valid), 32'd0);
  endtask

  task automatic check_reset_values(input string tag);
    chk({tag, "_req_ready"}, 32'(bus_if.req_ready), 32'd0);
    chk({tag, "_rsp_valid"}, 32'(bus_if.rsp_valid), 32'd0);
    chk({tag, "_quot"}, 32'(bus_if.rsp_quotient), 32'd0);
    chk({tag, "_rem"}, 32'(bus_if.rsp_reminder), 32'd0);
    chk({tag, "_dbz"}, 32'(bus_if.rsp_dbz), 32'd0);
    chk({tag, "_grant_id"}, 32'(grant_id), 32'd0);
    chk({tag, "_busy"}, 32'(busy), 32'd0);
    chk({tag, "_start"}, 32'(div_start), 32'd0);
    chk({tag, "_op_a"}, 32'(div_dividend), 32'd0);
    chk({tag, "_op_b"}, 32'(div_divisor), 32'd0);
  endtask

  initial begin
    int n;
    bus_if.req_valid    = '0;
    bus_if.req_dividend = '0;
    bus_if.req_divisor  = '0;
    bus_if.rsp_ready    = '0;
    #1;
    check_reset_values("reset");
    tick();
    tick();
    rst_n = 1'b1;

    // Single request 100/7 on client 0.
    post(0, 8'd100, 8'd7);
    serve(0);
    // Move the pointer back to 0.
    post(3, 8'($urandom_range(0, 255)), 8'($urandom_range(1, 255)));
    serve(0);

    // All four at once, 200/(k+1); client 0 re-requests after its grant.
    for (int k = 0; k < N_REQ; k++) post(k, 8'd200, 8'(k + 1));
    serve(0);
    post(0, 8'd200, 8'd9);
    for (int k = 0; k < N_REQ; k++) serve(0);

    // Response backpressure on client 2 with client 0 waiting.
    post(2, 8'd77, 8'd5);
    post(0, 8'd31, 8'd4);
    serve(5);
    serve(0);

    // Divide by zero.
    post(1, 8'd55, 8'd0);
    serve(0);

    // Divider not ready: request waits, accepted once ready returns.
    hold_rdy = 1'b1;
    post(1, 8'($urandom_range(0, 255)), 8'($urandom_range(1, 255)));
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("hold_req_ready", 32'(bus_if.req_ready), 32'd0);
      chk("hold_busy", 32'(busy), 32'd0);
    end
    hold_rdy = 1'b0;
    #1;
    chk("release_req_ready", 32'(bus_if.req_ready), 32'd2);
    serve(0);

    // Reset in the middle of WAIT.
    post(0, 8'd200, 8'd3);
    #1;
    n = 0;
    while (((bus_if.req_ready & bus_if.req_valid) == '0) && n < 60) begin
      tick();
      n++;
    end
    chk("rst_accept", 32'(bus_if.req_ready), 32'd1);
    tick();
    pend = '0;
    bus_if.req_valid = pend;
    tick();
    tick();
    chk("rst_wait_busy", 32'(busy), 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    check_reset_values("midrst");
    model_ptr = 0;
    tick();
    rst_n = 1'b1;
    inj_valid = 1'b1;
    tick();
    inj_valid = 1'b0;
    chk("stale_busy", 32'(busy), 32'd0);
    chk("stale_rsp_valid", 32'(bus_if.rsp_valid), 32'd0);
    post(2, 8'd9, 8'd3);
    serve(0);

    // Randomized traffic with persistent pending requests.
    for (int it = 0; it < 24; it++) begin
      for (int k = 0; k < N_REQ; k++) begin
        if (!pend[k] && $urandom_range(0, 1) == 1) begin
          post(k, 8'($urandom_range(0, 255)),
               ($urandom_range(0, 5) == 0) ? 8'd0 : 8'($urandom_range(1, 255)));
        end
      end
      if (pend == '0) post(int'($urandom_range(0, N_REQ - 1)), 8'($urandom_range(0, 255)), 8'($urandom_range(1, 255)));
      serve(int'($urandom_range(0, 3)));
    end
    n = 0;
    while (pend != '0 && n < 8) begin
      serve(0);
      n++;
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule : tb_div_arbiter

// File: doc/div_arbiter.md
# div_arbiter

Round-robin scheduler that shares one iterative restoring divider among N_REQ requesters. Each requester offers a dividend/divisor pair on a valid/ready channel. The block grants one request at a time, issues a one-cycle start to the divider and captures the divider's one-cycle result pulse. It then holds the result on a per-requester response channel until that requester accepts it. It sits between client logic and the divider, which it drives through the divider's start/ready/valid interface.

## Interface
- WORD_W, 8, operand/result width; must match the divider.
- N_REQ, 4, number of requesters, ≥2.
- ID_W, $clog2(N_REQ), width of the requester index (derived localparam).
- clk_i  in  1  clock, rising edge.
- rst_n_i  in  1  reset, asynchronous, active-low. The divider instance's active-high reset is driven with ~rst_n_i.
- req_valid_i  in  N_REQ  per-requester request valid.
- req_ready_o  out  N_REQ  per-requester request accept; one-hot or zero.
- req_dividend_i  in  N_REQ×WORD_W  dividends, packed, index k at [k*WORD_W +: WORD_W].
- req_divisor_i  in  N_REQ×WORD_W  divisors, same packing.
- rsp_valid_o  out  N_REQ  per-requester response valid; one-hot or zero.
- rsp_ready_i  in  N_REQ  per-requester response accept.
- rsp_quotient_o  out  WORD_W  quotient, shared by all requesters and qualified by rsp_valid_o.
- rsp_reminder_o  out  WORD_W  remainder, shared by all requesters.
- rsp_dbz_o  out  1  divide-by-zero flag, qualified by rsp_valid_o.
- grant_id_o  out  ID_W  index of the request in flight.
- busy_o  out  1  high in every state except IDLE.
- div_start_o  out  1  divider start pulse.
- div_dividend_o, div_divisor_o  out  WORD_W  latched operands to the divider.
- div_ready_i  in  1  divider idle.
- div_valid_i  in  1  divider result pulse.
- div_quotient_i, div_reminder_i  in  WORD_W  divider results.

## Operation
- FSM states and transitions:
  - IDLE: stays in IDLE until a request is accepted, then goes to ISSUE.
  - ISSUE: always lasts one cycle, then goes to WAIT (or to RESP when the zero check fires, see Configuration).
  - WAIT: stays in WAIT until div_valid_i, then goes to RESP.
  - RESP: stays in RESP until rsp_ready_i[id], then goes to IDLE.
- Arbitration, IDLE only:
  - The winner is the first k with req_valid_i[k], scanning from rr_ptr upward with wrap-around.
  - req_ready_o[winner] = 1 only when div_ready_i = 1.
  - On acceptance, the block latches the dividend, divisor and id. rr_ptr then becomes (winner+1) mod N_REQ.
  - req_ready_o is combinational from req_valid_i, rr_ptr, state and div_ready_i.
- ISSUE: div_start_o = 1 for exactly one cycle; div_dividend_o/div_divisor_o hold the latched operands from ISSUE through WAIT.
- WAIT: on div_valid_i, capture div_quotient_i/div_reminder_i into output registers.
- RESP: rsp_valid_o[id] = 1; quotient, remainder and dbz stay stable until rsp_ready_i[id]. No request is accepted in RESP.
- Result width equals WORD_W, with no truncation or extension.

## Timing
- Reset values: req_ready_o = 0, rsp_valid_o = 0, rsp_quotient_o = 0, rsp_reminder_o = 0, rsp_dbz_o = 0, grant_id_o = 0, busy_o = 0, div_start_o = 0, div operands = 0, rr_ptr = 0, state IDLE.
- Latency: with acceptance in cycle A, ISSUE is A+1. The divider raises valid at A+1+WORD_W+2. rsp_valid_o rises at A+WORD_W+4, i.e. A+12 for WORD_W = 8.
- Back-to-back throughput: the earliest next acceptance is the cycle after the response handshake.
- div_valid_i outside WAIT is ignored.
- When div_ready_i = 0 in IDLE, no request is accepted and pending requests wait.
- Asserting rst_n_i mid-operation returns the block to the reset values immediately (asynchronously). Any in-flight result is discarded and the divider is reset with it.
- rsp_ready_i on non-granted indices is ignored.

## Configuration
- Macro: DIV_ARBITER_ZERO_CHECK_EN.
- Defined:
  - In ISSUE, divisor == 0 suppresses div_start_o. The block loads quotient = all-ones, remainder = dividend and rsp_dbz_o = 1, then goes straight to RESP.
  - rsp_valid_o rises at A+2.
- Undefined:
  - A zero divisor is passed to the divider, which returns quotient = all-ones and remainder = dividend at the normal latency.
  - rsp_dbz_o is tied to 0.

## Structure
- Package div_arbiter_pkg holds:
  - the FSM state enum (IDLE_S, ISSUE_S, WAIT_S, RESP_S);
  - the constants for the zero-divisor result (all-ones quotient).
- Sub-module div_rr_pick is combinational. It takes req_valid, rr_ptr and enable, and produces a one-hot grant and its index; it is parameterised by N_REQ.
- The divider is instantiated by the parent, not inside this block.

## Test plan
All scenarios use WORD_W = 8 and N_REQ = 4.
- Single request, req 0 with 100/7 accepted at cycle A → div_start_o at A+1; rsp_valid_o[0] at A+12; quotient 14, remainder 2; rsp_dbz_o = 0.
- All four requests valid simultaneously with rr_ptr = 0 and each held until accepted, operands 200/k+1 → grants in order 0,1,2,3. Quotients 200, 100, 66, 50; remainders 0, 0, 2, 0. Req 0 is re-asserted after grant 0 and is served only after 3.
- Backpressure: rsp_ready_i[2] held low for 5 cycles → rsp_valid_o[2] stays high with outputs stable; req_ready_o is all zero throughout; IDLE is entered the cycle after ready.
- Divide by zero, 55/0:
  - With the macro → quotient 8'hFF, remainder 55, rsp_dbz_o = 1 at A+2, div_start_o never asserted.
  - Without the macro → the same values at A+12 with rsp_dbz_o = 0.
- Divider not ready: div_ready_i = 0 with req 1 valid → no req_ready_o. After div_ready_i rises, the request is accepted in that cycle.
- Reset during WAIT: rst_n_i pulled low → all outputs at reset values immediately. After release, a new 9/3 request completes with quotient 3, remainder 0, and the stale div_valid_i from before reset is ignored.
